// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 output stage: block/beat widths and the
// serializer state encoding.
package sm4_pkg;
  localparam int SM4_BLK_W     = 128;
  localparam int AXIS_W        = 32;
  localparam int BEATS_PER_BLK = SM4_BLK_W / AXIS_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_BLK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;
endpackage

// File: rtl/sm4_blk_fifo.sv
// Synchronous block FIFO with first-word-fall-through read data.
// A push into a full FIFO is discarded even when a pop happens on the same edge.
module sm4_blk_fifo
  import sm4_pkg::*;
#(
  parameter int WIDTH = SM4_BLK_W,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sm4_axis_master.sv
// AXI4-Stream master for SM4 cipher blocks: buffers 128-bit blocks and emits
// each as four 32-bit beats, most-significant word first, TLAST on the fourth.
module sm4_axis_master
  import sm4_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 M_AXIS_ACLK,
  input  logic                 M_AXIS_ARESETN,
  input  logic [SM4_BLK_W-1:0] data,
  input  logic                 datavalid,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TVALID,
  output logic [AXIS_W-1:0]    M_AXIS_TDATA,
  output logic [3:0]           M_AXIS_TSTRB,
  output logic                 M_AXIS_TLAST
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ser_state_e           state_r;
  ser_state_e           state_nxt_s;
  logic [1:0]           beat_r;
  logic [SM4_BLK_W-1:0] shift_r;
  logic                 tvalid_r;
  logic                 tlast_r;
  logic [3:0]           tstrb_r;

  logic [SM4_BLK_W-1:0] fifo_dout_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic [CW-1:0]        fifo_count_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 have_blk_s;
  logic                 load_s;
  logic                 advance_s;
  logic                 finish_s;

  assign push_s = datavalid & ~fifo_full_s;
  // Both FIFO status views must agree before a block is taken.
  assign have_blk_s = ~fifo_empty_s & (fifo_count_s != {CW{1'b0}});

  sm4_blk_fifo #(
    .WIDTH (SM4_BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .push  (push_s),
    .pop   (pop_s),
    .din   (data),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // Serializer next-state and FIFO pop decision.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (have_blk_s) begin
          pop_s       = 1'b1;
          load_s      = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (!M_AXIS_TREADY) begin
          state_nxt_s = SEND;
        end else if (beat_r != LAST_BEAT) begin
          advance_s = 1'b1;
        end else if (have_blk_s) begin
          pop_s  = 1'b1;
          load_s = 1'b1;
        end else begin
          finish_s    = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Serializer state, shift register and registered AXIS outputs.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_r  <= IDLE;
      beat_r   <= 2'd0;
      shift_r  <= {SM4_BLK_W{1'b0}};
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tstrb_r  <= 4'h0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        shift_r  <= fifo_dout_s;
        beat_r   <= 2'd0;
        tvalid_r <= 1'b1;
        tlast_r  <= 1'b0;
        tstrb_r  <= 4'hF;
      end else if (advance_s) begin
        shift_r <= {shift_r[SM4_BLK_W-AXIS_W-1:0], {AXIS_W{1'b0}}};
        beat_r  <= beat_r + 2'd1;
        tlast_r <= ((beat_r + 2'd1) == LAST_BEAT);
      end else if (finish_s) begin
        shift_r  <= {SM4_BLK_W{1'b0}};
        beat_r   <= 2'd0;
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
        tstrb_r  <= 4'h0;
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  assign M_AXIS_TVALID = tvalid_r;
  assign M_AXIS_TDATA  = shift_r[SM4_BLK_W-1 -: AXIS_W];
  assign M_AXIS_TSTRB  = tstrb_r;
  assign M_AXIS_TLAST  = tlast_r;

endmodule

// File: tb/tb_sm4_axis_master.sv
// Directed bench for sm4_axis_master: table of blocks with hand-written
// expected beats, replayed under several TREADY patterns.
module tb_sm4_axis_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data;
  logic         datavalid;
  logic         tready;
  logic         tvalid;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;

  always #5 clk = ~clk;

  sm4_axis_master #(.FIFO_DEPTH(8)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .data           (data),
    .datavalid      (datavalid),
    .M_AXIS_TREADY  (tready),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast)
  );

  typedef struct {
    logic [127:0] blk;
    logic [31:0]  b0;
    logic [31:0]  b1;
    logic [31:0]  b2;
    logic [31:0]  b3;
  } vec_t;

  vec_t         tbl [10];
  logic [127:0] src_q [$];
  int           pc_q [$];
  logic [36:0]  exp_q [$];
  logic [36:0]  cap_q [$];
  int           cap_cyc [$];
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  int           run_start = 0;

  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data = 32'h0;
  logic         prev_last = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake with its cycle number.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      cap_q.push_back({tstrb, tlast, tdata});
      cap_cyc.push_back(cyc);
    end
  end

  // A stalled beat must hold until it is accepted.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("hold_tvalid", {127'h0, tvalid}, 128'h1);
      check("hold_tdata", {96'h0, tdata}, {96'h0, prev_data});
      check("hold_tlast", {127'h0, tlast}, {127'h0, prev_last});
    end
    prev_stall <= rst_n && tvalid && !tready;
    prev_data  <= tdata;
    prev_last  <= tlast;
  end

  task automatic clr();
    src_q.delete();
    pc_q.delete();
    exp_q.delete();
  endtask

  task automatic add_blk(input int i, input int c, input bit emitted);
    src_q.push_back(tbl[i].blk);
    pc_q.push_back(c);
    if (emitted) begin
      exp_q.push_back({4'hF, 1'b0, tbl[i].b0});
      exp_q.push_back({4'hF, 1'b0, tbl[i].b1});
      exp_q.push_back({4'hF, 1'b0, tbl[i].b2});
      exp_q.push_back({4'hF, 1'b1, tbl[i].b3});
    end
  endtask

  // mode 0: TREADY high; 1: random TREADY; 2: TREADY low until cycle 14.
  task automatic run(input string tag, input int mode, input int budget);
    int idx;
    int last_pc;
    int n;
    idx = 0;
    last_pc = (pc_q.size() > 0) ? pc_q[pc_q.size()-1] : 0;
    cap_q.delete();
    cap_cyc.delete();
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) run_start = cyc;
      if (idx < src_q.size() && pc_q[idx] == c) begin
        data = src_q[idx];
        datavalid = 1'b1;
        idx++;
      end else begin
        data = 128'h0;
        datavalid = 1'b0;
      end
      case (mode)
        0: tready = 1'b1;
        1: tready = ($urandom_range(0, 1) == 1);
        2: tready = (c >= 14);
        default: tready = 1'b1;
      endcase
      if (idx == src_q.size() && cap_q.size() >= exp_q.size() && c >= last_pc + 20) break;
    end
    datavalid = 1'b0;
    tready = 1'b1;
    check({tag, "_nbeats"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_beat%0d", tag, i), cap_q[i], exp_q[i]);
    end
    @(negedge clk);
    check({tag, "_idle"}, {127'h0, tvalid}, 128'h0);
  endtask

  initial begin
    tbl[0] = '{128'h00000001_00000002_00000003_00000004, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
    tbl[1] = '{128'h00000005_00000006_00000007_00000008, 32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008};
    tbl[2] = '{128'h00000009_00000010_00000011_00000012, 32'h00000009, 32'h00000010, 32'h00000011, 32'h00000012};
    tbl[3] = '{128'h00000013_00000014_00000015_00000016, 32'h00000013, 32'h00000014, 32'h00000015, 32'h00000016};
    tbl[4] = '{128'h00000017_00000018_00000019_00000020, 32'h00000017, 32'h00000018, 32'h00000019, 32'h00000020};
    tbl[5] = '{128'h00000021_00000022_00000023_00000024, 32'h00000021, 32'h00000022, 32'h00000023, 32'h00000024};
    tbl[6] = '{128'h00000025_00000026_00000027_00000028, 32'h00000025, 32'h00000026, 32'h00000027, 32'h00000028};
    tbl[7] = '{128'h00000029_00000030_00000031_00000032, 32'h00000029, 32'h00000030, 32'h00000031, 32'h00000032};
    tbl[8] = '{128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
    tbl[9] = '{128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};

    rst_n = 1'b0;
    tready = 1'b0;
    datavalid = 1'b0;
    data = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {127'h0, tvalid}, 128'h0);
    check("rst_tstrb", {124'h0, tstrb}, 128'h0);
    check("rst_tlast", {127'h0, tlast}, 128'h0);
    check("rst_tdata", {96'h0, tdata}, 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single block: beat0 is visible one cycle after the write edge.
    clr();
    add_blk(0, 0, 1'b1);
    run("single", 0, 200);
    if (cap_cyc.size() == 4) begin
      check("single_latency", cap_cyc[0] - run_start, 2);
      check("single_contig", cap_cyc[3] - cap_cyc[0], 3);
    end

    // Eight back-to-back blocks, TREADY high: 32 contiguous beats.
    clr();
    for (int i = 0; i < 8; i++) add_blk(i, i, 1'b1);
    run("burst", 0, 400);
    if (cap_cyc.size() == 32) check("burst_contig", cap_cyc[31] - cap_cyc[0], 31);

    // Same burst under random backpressure.
    clr();
    for (int i = 0; i < 8; i++) add_blk(i, i, 1'b1);
    run("bp", 1, 2000);

    // Ten blocks while stalled: one sits in the serializer, eight fill the FIFO, the tenth is lost.
    clr();
    for (int i = 0; i < 10; i++) add_blk(i, i, (i < 9));
    run("ovf", 2, 600);

    // Second block written on the edge where the first block's last beat handshakes.
    clr();
    add_blk(0, 0, 1'b1);
    add_blk(1, 5, 1'b1);
    run("b2b", 0, 200);
    if (cap_cyc.size() == 8) begin
      check("b2b_gap", cap_cyc[4] - cap_cyc[3], 2);
      check("b2b_first", cap_cyc[3] - cap_cyc[0], 3);
    end

    // Reset in the middle of a block.
    @(posedge clk);
    #1 data = tbl[2].blk; datavalid = 1'b1; tready = 1'b1;
    @(posedge clk);
    #1 data = tbl[3].blk;
    @(posedge clk);
    #1 datavalid = 1'b0;
    @(posedge clk);
    #2 check("mid_pre_tvalid", {127'h0, tvalid}, 128'h1);
    rst_n = 1'b0;
    #1;
    check("mid_tvalid", {127'h0, tvalid}, 128'h0);
    check("mid_tstrb", {124'h0, tstrb}, 128'h0);
    check("mid_tlast", {127'h0, tlast}, 128'h0);
    check("mid_tdata", {96'h0, tdata}, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    run("stale", 0, 40);

    // Recovery after reset.
    clr();
    add_blk(1, 0, 1'b1);
    run("recover", 0, 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
